clic_target_pipe: RTL and testbench
===================================

Name: clic_target_pipe

Overview:
Parametrised successor to the CLIC interrupt generator. It selects the highest-priority pending and enabled source using an optionally pipelined max-tree. Interrupts are forwarded only when their priority exceeds a runtime threshold. Before the core accepts, a pending request is pre-empted in place by a strictly higher-priority arrival. Sits between the CLIC register file (ip/ie/le/prio) and the core's irq valid/ready port.

Parameters:
N_SOURCE, 256, number of interrupt sources (>= 2).
PrioWidth, 8, priority/level width.
PipeStages, 0, pipeline registers inside the tree (0..$clog2(N_SOURCE)); tree latency in cycles.
SrcWidth, $clog2(N_SOURCE), derived, not user-settable.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
ip_i  in  N_SOURCE  interrupt pending
ie_i  in  N_SOURCE  interrupt enable
le_i  in  N_SOURCE  1 = edge-triggered, 0 = level-sensitive
prio_i  in  PrioWidth x N_SOURCE  per-source priority
thresh_i  in  PrioWidth  interrupt threshold (mintthresh)
claim_o  out  N_SOURCE  one-cycle one-hot claim pulse
irq_valid_o  out  1  request to core
irq_ready_i  in  1  core accept
irq_id_o  out  SrcWidth  requested source id
irq_max_o  out  PrioWidth  requested priority

Behaviour:
- Reset: one clock, synchronous active-low reset; all state sampled on rising clk_i with rst_ni low. On reset:
  - irq_valid_o = 0, irq_id_o = 0, irq_max_o = 0, claim_o = 0.
  - FSM = IDLE; drain counter = 0; all tree pipeline registers invalid/zero.
- Leaves: leaf valid = ip_i[i] & ie_i[i]; id = i; prio = prio_i[i]. Padding leaves above N_SOURCE are invalid.
- Tree node selection:
  - Only one child valid: forward that child.
  - Both valid: forward the child with strictly greater prio; on a tie the lower id (C0) wins.
- Pipelining: PipeStages register stages are spaced evenly across levels, with registers placed after levels. Root result lags inputs by exactly PipeStages cycles.
- Root qualification: root_valid = root.is & (root.max > thresh_i). thresh_i is applied unregistered at the root.
- FSM states: IDLE, ACK, CLAIM, DRAIN.
- IDLE: if root_valid, capture root id/max, set valid = 1 next cycle, go to ACK.
- ACK: valid held high. Priority order within the cycle:
  1. Withdraw: (!le_i[id_q] & !ip_i[id_q]) or !ie_i[id_q] → valid = 0, go to IDLE.
  2. Accept: valid & ready → valid = 0, go to CLAIM. Accept wins over pre-emption in the same cycle.
  3. Pre-empt: root_valid & root.max > max_q → replace id/max next cycle, stay in ACK, valid stays 1.
  - Payload may change while valid is high. The core must sample id/max only in the accept cycle.
- CLAIM: claim_o[id_q] = 1 for exactly one cycle.
  - If PipeStages == 0, go to IDLE.
  - Otherwise load drain counter with PipeStages and go to DRAIN.
- DRAIN: no new request is issued. Counter decrements each cycle; at count 1, go to IDLE. This flushes stale entries for the claimed source out of the pipeline.
- Drain counter width: $clog2(PipeStages+1), minimum 1.
- Default/illegal state → IDLE.
- Throughput:
  - PipeStages = 0: back-to-back accepts every 3 cycles (ACK → CLAIM → IDLE).
  - Otherwise: every 3 + PipeStages cycles.
- thresh_i changes while in ACK do not retract the pending request.

Decomposition:
- clic_pkg: irq_state_e enum (IDLE, ACK, CLAIM, DRAIN; 2 bits) and the node struct {is, id, max} type builder function or parameterised typedef.
- Sub-module clic_max_tree: parametrised pipelined tree (N_SOURCE, PrioWidth, PipeStages), exposing is/id/max at the root.
- clic_target_pipe holds root qualification, FSM, drain counter and output registers.

Test Plan:
- Single source: N_SOURCE=8, PipeStages=0, src 5 prio 3, thresh 0, ready held 1 → valid rises 1 cycle later with id=5, max=3; claim_o=8'h20 for one cycle; FSM back in IDLE.
- Tie and threshold: srcs 2 and 6 both prio 4, thresh 0 → id=2; repeat with thresh 4 → valid never asserts; thresh 3 → id=2.
- Pre-emption: ready=0; src 1 prio 2 pending → id=1, max=2; then src 7 prio 9 asserts → next cycle id=7, max=9 with valid never dropping; then ready=1 → claim_o[7] pulses.
- Level withdraw: le_i[3]=0, src 3 pending, ready=0 → ACK; drop ip_i[3] → valid falls next cycle, no claim pulse. Edge source (le=1) with ip dropped → valid stays 1.
- Pipeline drain: N_SOURCE=256, PipeStages=2, src 200 prio 5, ip cleared on claim → valid 3 cycles after ip rises (2 pipe + 1 out reg); after claim, 2 DRAIN cycles; no re-request of src 200.
- Reset mid-operation: rst_ni low for one cycle while in ACK with valid=1 → next cycle valid=0, id=0, max=0, claim_o=0; a pending source re-requests after PipeStages+1 cycles.

Source files
------------

// File: rtl/clic_pkg.sv
// Shared types and elaboration helpers for the CLIC target pipeline.
// The node struct lives in clic_max_tree because its widths depend on module parameters.
package clic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    CLAIM = 2'd2,
    DRAIN = 2'd3
  } irq_state_e;

  // Spread `stages` registers evenly over `levels` tree levels: a register follows
  // level l when floor(l*S/L) steps up relative to level l-1.
  function automatic bit reg_after_level(input int unsigned level,
                                         input int unsigned levels,
                                         input int unsigned stages);
    return ((level * stages) / levels) != (((level - 1) * stages) / levels);
  endfunction

endpackage

// File: rtl/clic_max_tree.sv
// Heap-indexed max-tree over the pending sources. Optional registers are placed
// after levels, so the root lags the leaves by exactly PipeStages cycles.
module clic_max_tree
  import clic_pkg::*;
#(
  parameter  int N_SOURCE   = 256,
  parameter  int PrioWidth  = 8,
  parameter  int PipeStages = 0,
  localparam int SrcWidth   = $clog2(N_SOURCE)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_SOURCE-1:0]                 valid_i,
  input  logic [N_SOURCE-1:0][PrioWidth-1:0]  prio_i,
  output logic                                is_o,
  output logic [SrcWidth-1:0]                 id_o,
  output logic [PrioWidth-1:0]                max_o
);

  localparam int Levels = SrcWidth;
  localparam int NLeaf  = 2 ** Levels;

  typedef struct packed {
    logic                 is;
    logic [SrcWidth-1:0]  id;
    logic [PrioWidth-1:0] max;
  } node_t;

  // nd[1] is the root; children of node k are 2k and 2k+1; leaves start at NLeaf.
  node_t nd [1:2*NLeaf-1];

  for (genvar i = 0; i < NLeaf; i++) begin : g_leaf
    if (i < N_SOURCE) begin : g_src
      assign nd[NLeaf+i] = '{is: valid_i[i], id: SrcWidth'(i), max: prio_i[i]};
    end else begin : g_pad
      assign nd[NLeaf+i] = '0;
    end
  end

  for (genvar l = 1; l <= Levels; l++) begin : g_lvl
    for (genvar j = 0; j < (NLeaf >> l); j++) begin : g_node
      localparam int K = (NLeaf >> l) + j;
      node_t c0, c1, sel;

      assign c0 = nd[2*K];
      assign c1 = nd[2*K+1];

      // C1 only wins on a strictly greater priority, so ties go to the lower id.
      always_comb begin
        sel = c0;
        if (c1.is && (!c0.is || (c1.max > c0.max))) sel = c1;
      end

      if (reg_after_level(l, Levels, PipeStages)) begin : g_reg
        node_t q;
        always_ff @(posedge clk_i) begin
          if (!rst_ni) q <= '0;
          else         q <= sel;
        end
        assign nd[K] = q;
      end else begin : g_comb
        assign nd[K] = sel;
      end
    end
  end

  assign is_o  = nd[1].is;
  assign id_o  = nd[1].id;
  assign max_o = nd[1].max;

endmodule

// File: rtl/clic_target_pipe.sv
// CLIC target: threshold-qualified max-tree result feeding a valid/ready request
// with in-place pre-emption, one-cycle claim pulse and a pipeline drain after claim.
module clic_target_pipe
  import clic_pkg::*;
#(
  parameter  int N_SOURCE   = 256,
  parameter  int PrioWidth  = 8,
  parameter  int PipeStages = 0,
  localparam int SrcWidth   = $clog2(N_SOURCE)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_SOURCE-1:0]                 ip_i,
  input  logic [N_SOURCE-1:0]                 ie_i,
  input  logic [N_SOURCE-1:0]                 le_i,
  input  logic [N_SOURCE-1:0][PrioWidth-1:0]  prio_i,
  input  logic [PrioWidth-1:0]                thresh_i,
  output logic [N_SOURCE-1:0]                 claim_o,
  output logic                                irq_valid_o,
  input  logic                                irq_ready_i,
  output logic [SrcWidth-1:0]                 irq_id_o,
  output logic [PrioWidth-1:0]                irq_max_o
);

  localparam int CntW = (PipeStages == 0) ? 1 : $clog2(PipeStages + 1);

  logic                 root_is, root_valid;
  logic [SrcWidth-1:0]  root_id;
  logic [PrioWidth-1:0] root_max;

  irq_state_e           state_q, state_d;
  logic                 valid_q, valid_d;
  logic [SrcWidth-1:0]  id_q, id_d;
  logic [PrioWidth-1:0] max_q, max_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  clic_max_tree #(
    .N_SOURCE   (N_SOURCE),
    .PrioWidth  (PrioWidth),
    .PipeStages (PipeStages)
  ) u_tree (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (ip_i & ie_i),
    .prio_i  (prio_i),
    .is_o    (root_is),
    .id_o    (root_id),
    .max_o   (root_max)
  );

  // Threshold is applied unregistered at the root, after any tree latency.
  assign root_valid = root_is && (root_max > thresh_i);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (root_valid) begin
          state_d = ACK;
          valid_d = 1'b1;
          id_d    = root_id;
          max_d   = root_max;
        end
      end
      ACK: begin
        // Withdraw beats accept, accept beats pre-emption.
        if ((!le_i[id_q] && !ip_i[id_q]) || !ie_i[id_q]) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (valid_q && irq_ready_i) begin
          state_d = CLAIM;
          valid_d = 1'b0;
        end else if (root_valid && (root_max > max_q)) begin
          id_d  = root_id;
          max_d = root_max;
        end
      end
      CLAIM: begin
        if (PipeStages == 0) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
          cnt_d   = CntW'(PipeStages);
        end
      end
      DRAIN: begin
        // Hold off new requests until tree entries older than the claim are gone.
        if (cnt_q <= CntW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    claim_o = '0;
    if (state_q == CLAIM) claim_o[id_q] = 1'b1;
  end

  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign irq_max_o   = max_q;

endmodule

// File: tb/tb_clic_target_pipe.sv
// Two targets (PipeStages 0 and 2, 12 sources with tree padding) share stimulus;
// each is compared every cycle against a queue-of-best-results request model.
module tb_clic_target_pipe;

  localparam int NS = 12;
  localparam int PW = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NS-1:0]      ip, ie, le;
  logic [NS-1:0][PW-1:0] prio;
  logic [PW-1:0]      thresh;
  logic               ready;

  logic               a_valid, b_valid;
  logic [3:0]         a_id, b_id;
  logic [PW-1:0]      a_max, b_max;
  logic [NS-1:0]      a_claim, b_claim;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 waiting for core, 2 claiming, 3 draining.
  int m_st[2], m_id[2], m_mx[2], m_vld[2], m_cnt[2];
  bit hv[2][3];
  int hid[2][3], hmx[2][3];

  always #5 clk = ~clk;

  clic_target_pipe #(.N_SOURCE(NS), .PrioWidth(PW), .PipeStages(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .ip_i(ip), .ie_i(ie), .le_i(le), .prio_i(prio),
    .thresh_i(thresh), .claim_o(a_claim), .irq_valid_o(a_valid), .irq_ready_i(ready),
    .irq_id_o(a_id), .irq_max_o(a_max));

  clic_target_pipe #(.N_SOURCE(NS), .PrioWidth(PW), .PipeStages(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .ip_i(ip), .ie_i(ie), .le_i(le), .prio_i(prio),
    .thresh_i(thresh), .claim_o(b_claim), .irq_valid_o(b_valid), .irq_ready_i(ready),
    .irq_id_o(b_id), .irq_max_o(b_max));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int d);
    int p, bid, bmx, r_id, r_mx;
    bit bv, r_v, rv;
    p = (d == 0) ? 0 : 2;
    if (!rst_n) begin
      m_st[d] = 0; m_id[d] = 0; m_mx[d] = 0; m_vld[d] = 0; m_cnt[d] = 0;
      for (int k = 0; k < 3; k++) begin hv[d][k] = 0; hid[d][k] = 0; hmx[d][k] = 0; end
      return;
    end
    bv = 0; bid = 0; bmx = 0;
    for (int i = 0; i < NS; i++)
      if (ip[i] && ie[i] && (!bv || int'(prio[i]) > bmx)) begin
        bv = 1; bid = i; bmx = int'(prio[i]);
      end
    if (p == 0) begin r_v = bv; r_id = bid; r_mx = bmx; end
    else begin r_v = hv[d][p-1]; r_id = hid[d][p-1]; r_mx = hmx[d][p-1]; end
    rv = r_v && (r_mx > int'(thresh));
    case (m_st[d])
      0: if (rv) begin m_st[d] = 1; m_vld[d] = 1; m_id[d] = r_id; m_mx[d] = r_mx; end
      1: begin
        if ((!le[m_id[d]] && !ip[m_id[d]]) || !ie[m_id[d]]) begin m_st[d] = 0; m_vld[d] = 0; end
        else if (ready) begin m_st[d] = 2; m_vld[d] = 0; end
        else if (rv && r_mx > m_mx[d]) begin m_id[d] = r_id; m_mx[d] = r_mx; end
      end
      2: if (p == 0) m_st[d] = 0; else begin m_st[d] = 3; m_cnt[d] = p; end
      default: if (m_cnt[d] == 1) begin m_st[d] = 0; m_cnt[d] = 0; end
               else m_cnt[d] = m_cnt[d] - 1;
    endcase
    for (int k = 2; k > 0; k--) begin
      hv[d][k] = hv[d][k-1]; hid[d][k] = hid[d][k-1]; hmx[d][k] = hmx[d][k-1];
    end
    hv[d][0] = bv; hid[d][0] = bid; hmx[d][0] = bmx;
  endtask

  task automatic step();
    logic [31:0] exp_claim;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      model_update(d);
      exp_claim = (m_st[d] == 2) ? (32'd1 << m_id[d]) : 32'd0;
      chk(d ? "b_valid" : "a_valid", d ? 32'(b_valid) : 32'(a_valid), 32'(m_vld[d]));
      chk(d ? "b_id"    : "a_id",    d ? 32'(b_id)    : 32'(a_id),    32'(m_id[d]));
      chk(d ? "b_max"   : "a_max",   d ? 32'(b_max)   : 32'(a_max),   32'(m_mx[d]));
      chk(d ? "b_claim" : "a_claim", d ? 32'(b_claim) : 32'(a_claim), exp_claim);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; ip = '0; ie = '0; le = '0; prio = '0; thresh = '0; ready = 1'b0;
    step();
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_b_id", 32'(b_id), 0);
    chk("rst_a_claim", 32'(a_claim), 0);
    rst_n = 1'b1;
    steps(2);

    // Single source, ready held high.
    ie = '1; le = '1; prio[5] = 8'd3; ip = 12'h020; ready = 1'b1;
    step();
    chk("single_valid", 32'(a_valid), 1);
    chk("single_id", 32'(a_id), 5);
    chk("single_max", 32'(a_max), 3);
    ip = '0;
    step();
    chk("single_claim", 32'(a_claim), 32'h020);
    step();
    chk("single_claim_off", 32'(a_claim), 0);
    steps(6);

    // Tie resolves to lower id; threshold is a strict compare.
    ready = 1'b0; prio[2] = 8'd4; prio[6] = 8'd4; ip = 12'h044;
    steps(4);
    chk("tie_a_id", 32'(a_id), 2);
    chk("tie_b_id", 32'(b_id), 2);
    chk("tie_b_valid", 32'(b_valid), 1);
    ie = '0; steps(5);
    ie = '1; thresh = 8'd4;
    steps(5);
    chk("thr4_a_valid", 32'(a_valid), 0);
    chk("thr4_b_valid", 32'(b_valid), 0);
    thresh = 8'd3;
    steps(4);
    chk("thr3_a_id", 32'(a_id), 2);
    chk("thr3_b_valid", 32'(b_valid), 1);
    ie = '0; steps(5);
    ip = '0; ie = '1; thresh = '0;

    // Pre-emption in place.
    prio[1] = 8'd2; ip = 12'h002;
    steps(4);
    chk("pre_id0", 32'(a_id), 1);
    chk("pre_max0", 32'(a_max), 2);
    prio[7] = 8'd9; ip = 12'h082;
    step();
    chk("pre_valid", 32'(a_valid), 1);
    chk("pre_id1", 32'(a_id), 7);
    chk("pre_max1", 32'(a_max), 9);
    ready = 1'b1;
    step();
    chk("pre_claim", 32'(a_claim), 32'h080);
    ip = '0; ready = 1'b0;
    steps(6);

    // Level source withdraws, edge source holds.
    le[3] = 1'b0; prio[3] = 8'd5; ip = 12'h008;
    steps(4);
    chk("lvl_id", 32'(a_id), 3);
    ip = '0;
    step();
    chk("lvl_withdraw", 32'(a_valid), 0);
    chk("lvl_b_withdraw", 32'(b_valid), 0);
    chk("lvl_noclaim", 32'(a_claim), 0);
    steps(4);
    le = '1; ip = 12'h008;
    steps(4);
    ip = '0;
    step();
    chk("edge_hold_a", 32'(a_valid), 1);
    chk("edge_hold_b", 32'(b_valid), 1);
    ie = '0; steps(5);
    ie = '1;

    // Reset in the middle of a pending request.
    prio[4] = 8'd2; ip = 12'h010;
    steps(4);
    rst_n = 1'b0;
    step();
    chk("mid_rst_a_valid", 32'(a_valid), 0);
    chk("mid_rst_b_valid", 32'(b_valid), 0);
    chk("mid_rst_b_max", 32'(b_max), 0);
    rst_n = 1'b1;
    step();
    chk("rerq_a", 32'(a_valid), 1);
    chk("rerq_b_early", 32'(b_valid), 0);
    step();
    chk("rerq_b_early2", 32'(b_valid), 0);
    step();
    chk("rerq_b", 32'(b_valid), 1);
    ip = '0; steps(6);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) == 0) ip ^= NS'(1 << $urandom_range(0, NS-1));
      if ($urandom_range(0, 15) == 0) ie ^= NS'(1 << $urandom_range(0, NS-1));
      if ($urandom_range(0, 15) == 0) le ^= NS'(1 << $urandom_range(0, NS-1));
      if ($urandom_range(0, 3) == 0) prio[$urandom_range(0, NS-1)] = PW'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) thresh = PW'($urandom_range(0, 5));
      ready = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
